neuron_mac: RTL and testbench



---
 rtl/neuron_mac.sv | 148 ++++++++++++++
 tb/tb_neuron_mac.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate with bias, rescale and clamp
// Optional NEURON_SAT_EN: saturate the result instead of wrapping it to sumWidth bits.
module neuron_mac #(
    parameter int numWeights   = 256,
    parameter int addressWidth = 8,
    parameter int dataWidth    = 6,
    parameter int sumWidth     = 10,
    parameter int shiftBits    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [dataWidth-1:0]    inData,
    output logic                    weightReadEn,
    output logic [addressWidth-1:0] weightAddr,
    input  logic [dataWidth-1:0]    weightData,
    input  logic [sumWidth-1:0]     bias,
    output logic                    outValid,
    output logic [sumWidth-1:0]     sumOut
);
    localparam int PROD_W = 2 * dataWidth + 1;
    localparam int ACC_W  = 2 * dataWidth + addressWidth + 2;
    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeights - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        ACCUM,
        BIAS,
        OUT
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [addressWidth-1:0]  idx;
    logic signed [ACC_W-1:0]  acc;
    logic [sumWidth-1:0]      sum_q;
    logic                     out_valid_q;
    logic                     accept;
    logic                     last_accept;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic [sumWidth-1:0]      sum_next;

    assign accept      = (state == ACCUM) && inValid;
    assign last_accept = accept && (idx == LAST_IDX);

    // Activation is unsigned, so widen it with a zero sign bit before the signed multiply.
    assign prod     = $signed({1'b0, inData}) * $signed(weightData);
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W - sumWidth){bias[sumWidth-1]}}, bias};

`ifdef NEURON_SAT_EN
    localparam logic signed [ACC_W-1:0] SUM_MAX =
        {{(ACC_W - sumWidth + 1){1'b0}}, {(sumWidth - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN =
        {{(ACC_W - sumWidth + 1){1'b1}}, {(sumWidth - 1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc >>> shiftBits;

    always_comb begin
        sum_next = shifted[sumWidth-1:0];
        if (shifted > SUM_MAX) begin
            sum_next = SUM_MAX[sumWidth-1:0];
        end else if (shifted < SUM_MIN) begin
            sum_next = SUM_MIN[sumWidth-1:0];
        end
    end
`else
    assign sum_next = sumWidth'(acc >>> shiftBits);
`endif

    always_comb begin
        state_next   = state;
        busy         = 1'b1;
        inReady      = 1'b0;
        weightReadEn = 1'b0;
        weightAddr   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = PREFETCH;
                end
            end
            PREFETCH: begin
                weightReadEn = 1'b1;
                state_next   = ACCUM;
            end
            ACCUM: begin
                inReady = 1'b1;
                // Address the next weight now so it lands in time for a back-to-back accept.
                if (last_accept) begin
                    weightAddr = idx;
                    state_next = BIAS;
                end else begin
                    weightReadEn = 1'b1;
                    weightAddr   = idx + {{(addressWidth - 1){1'b0}}, accept};
                end
            end
            BIAS:    state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + prod_ext;
                        idx <= idx + 1'b1;
                    end
                end
                BIAS: acc <= acc + bias_ext;
                OUT: begin
                    sum_q       <= sum_next;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign outValid = out_valid_q;
    assign sumOut   = sum_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed bench for neuron_mac with an arithmetic result model
module tb_neuron_mac;
    localparam int NW = 4;
    localparam int AW = 8;
    localparam int DW = 6;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [SW-1:0] bias = '0;

    logic          busy0, in_ready0, wre0, ov0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [SW-1:0] so0;
    logic          busy1, in_ready1, wre1, ov1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [SW-1:0] so1;

    neuron_mac #(.numWeights(NW), .addressWidth(AW), .dataWidth(DW), .sumWidth(SW), .shiftBits(0)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy0),
        .inValid(in_valid), .inReady(in_ready0), .inData(in_data),
        .weightReadEn(wre0), .weightAddr(wa0), .weightData(wd0),
        .bias(bias), .outValid(ov0), .sumOut(so0)
    );

    neuron_mac #(.numWeights(NW), .addressWidth(AW), .dataWidth(DW), .sumWidth(SW), .shiftBits(2)) dut_sh (
        .clk(clk), .rst(rst), .start(start), .busy(busy1),
        .inValid(in_valid), .inReady(in_ready1), .inData(in_data),
        .weightReadEn(wre1), .weightAddr(wa1), .weightData(wd1),
        .bias(bias), .outValid(ov1), .sumOut(so1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (wre0) wd0 <= mem[wa0];
        if (wre1) wd1 <= mem[wa1];
    end

    int xs [NW];
    int ws [NW];

    typedef struct {
        int at;
        int v0;
        int v1;
    } exp_t;
    exp_t q[$];
    int held0 = 0;
    int held1 = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sx(input logic [SW-1:0] v);
        return {{(32 - SW){v[SW-1]}}, v};
    endfunction

    // Result of one evaluation straight from the arithmetic definition.
    function automatic int model(input int sh, input int b);
        int s;
        s = 0;
        for (int k = 0; k < NW; k++) s += xs[k] * ws[k];
        s += b;
        s = s >>> sh;
`ifdef NEURON_SAT_EN
        if (s > 511) s = 511;
        if (s < -512) s = -512;
`else
        s = s & 1023;
        if (s >= 512) s -= 1024;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].at == cyc) begin
                check("out_valid", ov0, 1);
                check("out_valid_sh", ov1, 1);
                check("sum_out", sx(so0), q[0].v0);
                check("sum_out_sh", sx(so1), q[0].v1);
                held0 = q[0].v0;
                held1 = q[0].v1;
                void'(q.pop_front());
            end else begin
                check("out_valid_idle", ov0, 0);
                check("out_valid_idle_sh", ov1, 0);
                check("sum_hold", sx(so0), held0);
                check("sum_hold_sh", sx(so1), held1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) mem[i] = (i < NW) ? DW'(ws[i]) : '0;
    endtask

    task automatic run_eval(input logic [NW-1:0] gaps, input int b, input bit pre,
                            input bit chain, input bit poke, input int lit0, input int lit1);
        int t_last;
        t_last = 0;
        if (!pre) begin
            step();
            start = 1'b1;
            @(negedge clk);
            check("busy_idle", busy0, 0);
        end
        bias = SW'(b);
        step();
        start = 1'b0;
        @(negedge clk);
        check("busy_prefetch", busy0, 1);
        check("busy_prefetch_sh", busy1, 1);
        check("prefetch_ren", wre0, 1);
        check("prefetch_addr", wa0, 0);
        step();
        for (int k = 0; k < NW; k++) begin
            if (gaps[k]) begin
                in_valid = 1'b0;
                in_data  = 6'h2A;
                start    = poke;
                @(negedge clk);
                check("gap_addr", wa0, k);
                check("gap_ren", wre0, 1);
                check("gap_ready", in_ready0, 1);
                step();
            end
            in_valid = 1'b1;
            in_data  = DW'(xs[k]);
            start    = poke && (k == 1);
            @(negedge clk);
            check("accum_ready", in_ready0, 1);
            check("accum_ready_sh", in_ready1, 1);
            if (k < NW - 1) begin
                check("accum_addr", wa0, k + 1);
                check("accum_ren", wre0, 1);
            end else begin
                check("last_ren", wre0, 0);
                t_last = cyc;
            end
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        q.push_back('{t_last + 3, model(0, b), model(2, b)});
        check("bias_ready", in_ready0, 0);
        step();
        step();
        if (chain) start = 1'b1;
        @(negedge clk);
        check("result_cycle", cyc, t_last + 3);
        check("lit_sum", sx(so0), lit0);
        check("lit_sum_sh", sx(so1), lit1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: actual cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        ws = '{1, 2, 3, -1};
        xs = '{10, 5, 0, 7};
        load_mem();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_out_valid", ov0, 0);
        check("rst_sum", sx(so0), 0);
        check("rst_ready", in_ready0, 0);
        check("rst_ren", wre0, 0);
        check("rst_addr", wa0, 0);
        step();
        rst = 1'b0;

        run_eval(4'b0000, 0, 1'b0, 1'b0, 1'b0, 13, 3);
        run_eval(4'b0000, -20, 1'b0, 1'b0, 1'b0, -7, -2);
        run_eval(4'b1111, -20, 1'b0, 1'b0, 1'b0, -7, -2);
        run_eval(4'b0000, -26, 1'b0, 1'b0, 1'b0, -13, -4);

        run_eval(4'b0100, 0, 1'b0, 1'b1, 1'b1, 13, 3);
        run_eval(4'b0000, 0, 1'b1, 1'b0, 1'b0, 13, 3);

        ws = '{31, 31, 31, 31};
        xs = '{63, 63, 63, 63};
        load_mem();
`ifdef NEURON_SAT_EN
        run_eval(4'b0000, 0, 1'b0, 1'b0, 1'b0, 511, 511);
`else
        run_eval(4'b0000, 0, 1'b0, 1'b0, 1'b0, -380, -95);
`endif

        ws = '{1, 2, 3, -1};
        xs = '{10, 5, 0, 7};
        load_mem();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = DW'(xs[0]);
        step();
        in_data  = DW'(xs[1]);
        step();
        in_valid = 1'b0;
        #2;
        rst   = 1'b1;
        held0 = 0;
        held1 = 0;
        @(negedge clk);
        check("abort_busy", busy0, 0);
        check("abort_busy_sh", busy1, 0);
        check("abort_out_valid", ov0, 0);
        check("abort_sum", sx(so0), 0);
        check("abort_sum_sh", sx(so1), 0);
        check("abort_ren", wre0, 0);
        check("abort_ready", in_ready0, 0);
        step();
        rst = 1'b0;

        run_eval(4'b0000, 0, 1'b0, 1'b0, 1'b0, 13, 3);
        repeat (3) step();
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
